cpu_param: RTL

CPU_PARAM -- requirements
Module: cpu_param

---
 rtl/cpu_param.sv | 118 +++++++++++
 1 files changed

// File: rtl/cpu_param.sv
// rtl/cpu_param.sv - single-cycle parameterised CPU with stall-aware retire, sticky illegal flag
module cpu_param #(
   parameter int DW = 8,
   parameter int RA = 3
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic [31:0]   INSTRUCTION,
   input  logic          I_BUSYWAIT,
   input  logic          D_BUSYWAIT,
   input  logic [DW-1:0] READDATA,
   output logic [31:0]   PC,
   output logic          READ,
   output logic          WRITE,
   output logic [DW-1:0] ADDRESS,
   output logic [DW-1:0] WRITEDATA,
   output logic [31:0]   RETIRED,
   output logic          ILLEGAL
);

   localparam int NREG = 2 ** RA;

   logic [DW-1:0] regs [NREG];

   logic [7:0]    opcode;
   logic [7:0]    imm8;
   logic [RA-1:0] rd_idx;
   logic [RA-1:0] rs1_idx;
   logic [RA-1:0] rs2_idx;
   logic [DW-1:0] r1;
   logic [DW-1:0] r2;
   logic [DW-1:0] imm;
   logic [DW-1:0] alu;
   logic [DW-1:0] wb_data;
   logic [31:0]   off_ext;
   logic [31:0]   pc_inc;
   logic [31:0]   pc_target;
   logic [31:0]   pc_next;
   logic [4:0]    shamt;
   logic          shift_over;
   logic          wb_en;
   logic          mem_read;
   logic          mem_write;
   logic          stall;
   logic          unused_bits;

   assign opcode  = INSTRUCTION[31:24];
   assign rd_idx  = INSTRUCTION[16 +: RA];
   assign rs1_idx = INSTRUCTION[8 +: RA];
   assign rs2_idx = INSTRUCTION[0 +: RA];
   assign imm8    = INSTRUCTION[7:0];
   assign unused_bits = ^INSTRUCTION[15:8];

   assign r1  = regs[rs1_idx];
   assign r2  = regs[rs2_idx];
   assign imm = DW'($signed(imm8));

   assign shamt      = imm8[4:0];
   assign shift_over = (32'(shamt) >= DW);

   assign off_ext   = 32'($signed(INSTRUCTION[23:16]));
   assign pc_inc    = PC + 32'd4;
   assign pc_target = pc_inc + {off_ext[29:0], 2'b00};

   always_comb begin
      alu     = '0;
      wb_en   = 1'b0;
      pc_next = pc_inc;
      case (opcode)
         8'd0:  begin alu = imm;     wb_en = 1'b1; end
         8'd1:  begin alu = r2;      wb_en = 1'b1; end
         8'd2:  begin alu = r1 + r2; wb_en = 1'b1; end
         8'd3:  begin alu = r1 - r2; wb_en = 1'b1; end
         8'd4:  begin alu = r1 & r2; wb_en = 1'b1; end
         8'd5:  begin alu = r1 | r2; wb_en = 1'b1; end
         8'd6:  pc_next = pc_target;
         8'd7:  if (r1 == r2) pc_next = pc_target;
         8'd8:  begin alu = r2;      wb_en = 1'b1; end
         8'd9:  begin alu = imm;     wb_en = 1'b1; end
         8'd10: alu = r2;
         8'd11: alu = imm;
         8'd12: if (r1 != r2) pc_next = pc_target;
         8'd13: begin alu = shift_over ? '0 : (r1 << shamt); wb_en = 1'b1; end
         8'd14: begin alu = shift_over ? '0 : (r1 >> shamt); wb_en = 1'b1; end
         8'd15: begin
            alu   = shift_over ? {DW{r1[DW-1]}} : DW'($signed(r1) >>> shamt);
            wb_en = 1'b1;
         end
         default: ;
      endcase
   end

   // Requests are masked while the instruction is not yet valid or reset is held
   assign mem_read  = (opcode == 8'd8)  || (opcode == 8'd9);
   assign mem_write = (opcode == 8'd10) || (opcode == 8'd11);
   assign READ      = RESET & ~I_BUSYWAIT & mem_read;
   assign WRITE     = RESET & ~I_BUSYWAIT & mem_write;
   assign ADDRESS   = alu;
   assign WRITEDATA = r1;

   assign wb_data = mem_read ? READDATA : alu;
   assign stall   = I_BUSYWAIT | ((READ | WRITE) & D_BUSYWAIT);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         PC      <= '0;
         RETIRED <= '0;
         ILLEGAL <= 1'b0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (!stall) begin
         PC      <= pc_next;
         RETIRED <= RETIRED + 32'd1;
         if (opcode > 8'd15) ILLEGAL <= 1'b1;
         if (wb_en) regs[rd_idx] <= wb_data;
      end
   end

endmodule
